// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo
// Single-clock FIFO with count-derived flags, error pulses and a build-time
// choice of registered-read or first-word-fall-through output.
// Rev    : 1.0
// ============================================================================
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter int FWFT       = 0,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_en,
    output logic                  rd_val,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CW-1:0]         count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int              c_PW        = $clog2(DEPTH);
    localparam logic [c_PW-1:0] c_PTR_LAST  = c_PW'(DEPTH - 1);
    localparam logic [CW-1:0]   c_CNT_FULL  = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]       r_head;
    logic [c_PW-1:0]       r_tail;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [c_PW-1:0]       w_head_nxt;
    logic [c_PW-1:0]       w_tail_nxt;

    // Full/empty come from the occupancy counter only, so any DEPTH works.
    assign w_full   = (r_count == c_CNT_FULL);
    assign w_empty  = (r_count == '0);

    // A request in the reset cycle is dropped entirely.
    assign w_wr_acc = wr_en && !w_full  && !reset;
    assign w_rd_acc = rd_en && !w_empty && !reset;

    // Explicit wrap at DEPTH-1; never rely on binary overflow.
    assign w_head_nxt = (r_head == c_PTR_LAST) ? '0 : r_head + 1'b1;
    assign w_tail_nxt = (r_tail == c_PTR_LAST) ? '0 : r_tail + 1'b1;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_tail] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_wr_acc) begin
                r_tail <= w_tail_nxt;
            end
            if (w_rd_acc) begin
                r_head <= w_head_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_wr_acc && !w_rd_acc) begin
            r_count <= r_count + 1'b1;
        end else if (!w_wr_acc && w_rd_acc) begin
            r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= wr_en && w_full;
            r_underflow <= rd_en && w_empty;
        end
    end

    assign wr_ready     = !w_full;
    assign rd_val       = !w_empty;
    assign count        = r_count;
    assign almost_full  = (int'(r_count) >= AF_LEVEL);
    assign almost_empty = (int'(r_count) <= AE_LEVEL);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; rd_en only acknowledges it.
            assign rd_data = r_mem[r_head];
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_rd_data;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rd_data <= '0;
                end else if (w_rd_acc) begin
                    r_rd_data <= r_mem[r_head];
                end
            end

            assign rd_data = r_rd_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_sync_fifo
// Bench for sync_fifo: a DEPTH=4 registered-read instance and a DEPTH=3 FWFT
// instance, checked against queue-based reference models.
// Rev    : 1.0
// ============================================================================
module tb_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       a_wr_en, a_rd_en;
    logic [7:0] a_wr_data;
    logic       a_wr_ready, a_rd_val, a_af, a_ae, a_ovf, a_unf;
    logic [7:0] a_rd_data;
    logic [2:0] a_count;

    logic       b_wr_en, b_rd_en;
    logic [7:0] b_wr_data;
    logic       b_wr_ready, b_rd_val, b_af, b_ae, b_ovf, b_unf;
    logic [7:0] b_rd_data;
    logic [1:0] b_count;

    sync_fifo #(.DATA_WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_a (
        .clk(clk), .reset(reset),
        .wr_en(a_wr_en), .wr_data(a_wr_data), .wr_ready(a_wr_ready),
        .rd_en(a_rd_en), .rd_val(a_rd_val), .rd_data(a_rd_data),
        .count(a_count), .almost_full(a_af), .almost_empty(a_ae),
        .overflow(a_ovf), .underflow(a_unf)
    );

    sync_fifo #(.DATA_WIDTH(8), .DEPTH(3), .AF_LEVEL(2), .AE_LEVEL(1), .FWFT(1)) u_b (
        .clk(clk), .reset(reset),
        .wr_en(b_wr_en), .wr_data(b_wr_data), .wr_ready(b_wr_ready),
        .rd_en(b_rd_en), .rd_val(b_rd_val), .rd_data(b_rd_data),
        .count(b_count), .almost_full(b_af), .almost_empty(b_ae),
        .overflow(b_ovf), .underflow(b_unf)
    );

    logic [16:0] a_act;
    logic [7:0]  b_act;
    assign a_act = {a_count, a_wr_ready, a_rd_val, a_af, a_ae, a_ovf, a_unf, a_rd_data};
    assign b_act = {b_count, b_wr_ready, b_rd_val, b_af, b_ae, b_ovf, b_unf};

    // Reference models: a queue of stored words plus the expected pulses.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] ma_rd;
    logic       ma_ovf, ma_unf, mb_ovf, mb_unf;

    int total = 0;
    int bad   = 0;

    function automatic logic [16:0] exp_a();
        int n = qa.size();
        return {3'(n), n < 4, n > 0, n >= 3, n <= 1, ma_ovf, ma_unf, ma_rd};
    endfunction

    function automatic logic [7:0] exp_b();
        int n = qb.size();
        return {2'(n), n < 3, n > 0, n >= 2, n <= 1, mb_ovf, mb_unf};
    endfunction

    task automatic idle();
        a_wr_en = 0; a_rd_en = 0; a_wr_data = 8'h00;
        b_wr_en = 0; b_rd_en = 0; b_wr_data = 8'h00;
    endtask

    // Advance one clock, apply the rules of the FIFO to the models, settle.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            qa.delete(); qb.delete();
            ma_rd = 8'h00; ma_ovf = 0; ma_unf = 0; mb_ovf = 0; mb_unf = 0;
        end else begin
            ma_ovf = a_wr_en && (qa.size() == 4);
            ma_unf = a_rd_en && (qa.size() == 0);
            if (a_rd_en && qa.size() > 0) ma_rd = qa.pop_front();
            if (a_wr_en && !ma_ovf) qa.push_back(a_wr_data);
            mb_ovf = b_wr_en && (qb.size() == 3);
            mb_unf = b_rd_en && (qb.size() == 0);
            if (b_rd_en && qb.size() > 0) void'(qb.pop_front());
            if (b_wr_en && !mb_ovf) qb.push_back(b_wr_data);
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        a_wr_en = 1; a_rd_en = 1; b_wr_en = 1; b_rd_en = 1;
        tick(); tick();
        reset = 0;
        idle();
        tick();
        total++;
        if (a_act !== 17'b000_1_0_0_1_0_0_00000000) begin
            bad++;
            $display("FAIL reset_a: got %h want %h", a_act, 17'b000_1_0_0_1_0_0_00000000);
        end
        total++;
        if (b_act !== 8'b00_1_0_0_1_0_0) begin
            bad++;
            $display("FAIL reset_b: got %b want %b", b_act, 8'b00_1_0_0_1_0_0);
        end
    endtask

    task automatic test_fill();
        logic [7:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i < 5) begin a_wr_en = 1; a_wr_data = vals[i]; end
            tick();
            total++;
            if (a_act !== exp_a()) begin
                bad++;
                $display("FAIL fill[%0d]: got %h want %h", i, a_act, exp_a());
            end
        end
        total++;
        if (a_count !== 3'd4 || a_ovf !== 1'b0) begin
            bad++;
            $display("FAIL fill_end: count=%0d ovf=%b want 4/0", a_count, a_ovf);
        end
    endtask

    task automatic test_drain();
        logic [7:0] want [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i < 5) a_rd_en = 1;
            tick();
            total++;
            if (a_act !== exp_a()) begin
                bad++;
                $display("FAIL drain[%0d]: got %h want %h", i, a_act, exp_a());
            end
            if (i < 4) begin
                total++;
                if (a_rd_data !== want[i]) begin
                    bad++;
                    $display("FAIL drain_data[%0d]: got %h want %h", i, a_rd_data, want[i]);
                end
            end
        end
        total++;
        if (a_rd_data !== 8'h44 || a_unf !== 1'b0) begin
            bad++;
            $display("FAIL drain_hold: data=%h unf=%b want 44/0", a_rd_data, a_unf);
        end
    endtask

    task automatic test_wrap();
        // {wr, rd} per cycle; simultaneous cycles occur at count 2 and 1
        logic [1:0] sched [14] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11,
                                   2'b10, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00};
        logic [7:0] got[$];
        logic [7:0] nxt = 8'h01;
        int         cnt_before;
        for (int i = 0; i < 14; i++) begin
            idle();
            b_wr_en = sched[i][1];
            b_rd_en = sched[i][0];
            b_wr_data = nxt;
            if (b_wr_en) nxt++;
            if (b_rd_en && b_rd_val) got.push_back(b_rd_data);
            cnt_before = qb.size();
            tick();
            total++;
            if (b_act !== exp_b()) begin
                bad++;
                $display("FAIL wrap[%0d]: got %b want %b", i, b_act, exp_b());
            end
            if (sched[i] == 2'b11) begin
                total++;
                if (int'(b_count) != cnt_before) begin
                    bad++;
                    $display("FAIL wrap_simul[%0d]: count=%0d want %0d", i, b_count, cnt_before);
                end
            end
        end
        total++;
        if (got.size() != 10) begin
            bad++;
            $display("FAIL wrap_len: got %0d words want 10", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            total++;
            if (got[i] !== 8'(i + 1)) begin
                bad++;
                $display("FAIL wrap_order[%0d]: got %h want %h", i, got[i], 8'(i + 1));
            end
        end
    endtask

    task automatic test_fwft();
        idle();
        b_wr_en = 1; b_wr_data = 8'hA5;
        tick();
        idle();
        total++;
        if (b_rd_val !== 1'b1 || b_rd_data !== 8'hA5) begin
            bad++;
            $display("FAIL fwft_show: val=%b data=%h want 1/a5", b_rd_val, b_rd_data);
        end
        tick();
        total++;
        if (b_rd_val !== 1'b1 || b_rd_data !== 8'hA5) begin
            bad++;
            $display("FAIL fwft_hold: val=%b data=%h want 1/a5", b_rd_val, b_rd_data);
        end
        b_rd_en = 1;
        tick();
        idle();
        total++;
        if (b_rd_val !== 1'b0 || b_count !== 2'd0) begin
            bad++;
            $display("FAIL fwft_pop: val=%b count=%0d want 0/0", b_rd_val, b_count);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        a_wr_en = 1; a_wr_data = 8'h61; tick();
        a_wr_data = 8'h62; tick();
        reset = 1; a_wr_en = 1; a_rd_en = 1; a_wr_data = 8'h63;
        tick();
        reset = 0;
        idle();
        total++;
        if (a_count !== 3'd0 || a_rd_val !== 1'b0 || a_ovf !== 1'b0 || a_unf !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: count=%0d val=%b ovf=%b unf=%b want 0/0/0/0",
                     a_count, a_rd_val, a_ovf, a_unf);
        end
        // Pointers must be back at slot 0: a new word is the next one read.
        a_wr_en = 1; a_wr_data = 8'h7E; tick();
        idle(); a_rd_en = 1; tick();
        idle();
        total++;
        if (a_rd_data !== 8'h7E || a_count !== 3'd0) begin
            bad++;
            $display("FAIL reset_mid_ptr: data=%h count=%0d want 7e/0", a_rd_data, a_count);
        end
    endtask

    task automatic test_random();
        int wp;
        for (int i = 0; i < 400; i++) begin
            wp = ((i / 40) % 2 == 0) ? 75 : 25;
            a_wr_en   = ($urandom_range(0, 99) < wp);
            a_rd_en   = ($urandom_range(0, 99) < 100 - wp);
            a_wr_data = 8'($urandom);
            b_wr_en   = ($urandom_range(0, 99) < wp);
            b_rd_en   = ($urandom_range(0, 99) < 100 - wp);
            b_wr_data = 8'($urandom);
            tick();
            total++;
            if (a_act !== exp_a()) begin
                bad++;
                $display("FAIL rand_a[%0d]: got %h want %h", i, a_act, exp_a());
            end
            total++;
            if (b_act !== exp_b()) begin
                bad++;
                $display("FAIL rand_b[%0d]: got %b want %b", i, b_act, exp_b());
            end
            if (qb.size() > 0) begin
                total++;
                if (b_rd_data !== qb[0]) begin
                    bad++;
                    $display("FAIL rand_b_data[%0d]: got %h want %h", i, b_rd_data, qb[0]);
                end
            end
        end
        idle();
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_fwft();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
